// File: rtl/tree_acc_pkg.sv
// Shared types and helpers for the tree accumulator: FSM states, accumulator
// width check and a generic sign-extension helper.
package tree_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // True when an accumulator of acc_w bits can hold max_beats worst-case in_w-bit sums.
  function automatic bit acc_width_ok(input int in_w, input int max_beats, input int acc_w);
    return acc_w >= in_w + $clog2(max_beats);
  endfunction

  // Sign-extends the low 'width' bits of val to the full 64 bits.
  function automatic logic [63:0] sign_extend(input logic [63:0] val, input int width);
    logic signed [63:0] t;
    t = val << (64 - width);
    return t >>> (64 - width);
  endfunction

endpackage

// File: rtl/tree_acc_scale.sv
// Final-sum scaling: arithmetic right shift, then width reduction to OUT_WIDTH.
// Define TREE_ACC_SAT_EN for saturation; otherwise the result wraps and out_sat flags it.
module tree_acc_scale
  import tree_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W   = 5
) (
  input  logic [ACC_WIDTH-1:0] acc_in,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 sat
);

  logic signed [ACC_WIDTH-1:0] shifted;
  logic                        fits;

  always_comb begin
    shifted = '0;
    fits    = 1'b0;
    data    = '0;
    sat     = 1'b0;

    shifted = $signed(acc_in) >>> shift;
    // Value fits when every bit above the output sign bit copies that sign bit.
    fits = (shifted[ACC_WIDTH-1:OUT_WIDTH-1] == '0) ||
           (shifted[ACC_WIDTH-1:OUT_WIDTH-1] == '1);

`ifdef TREE_ACC_SAT_EN
    if (fits) begin
      data = shifted[OUT_WIDTH-1:0];
      sat  = 1'b0;
    end else begin
      data = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end
`else
    data = shifted[OUT_WIDTH-1:0];
    sat  = !fits;
`endif
  end

endmodule

// File: rtl/tree_accumulator.sv
// Frame accumulator behind the adder tree: sums signed beats per frame and hands one
// scaled result downstream over valid/ready. Saturation selected by TREE_ACC_SAT_EN.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACCUM | frame open, summing accepted beats
// HOLD  | result presented, waiting for out_ready
module tree_accumulator
  import tree_acc_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int MAX_BEATS = 256,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT_W   = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic                             in_last,
  input  logic [SHIFT_W-1:0]               cfg_shift,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic [$clog2(MAX_BEATS+1)-1:0]   out_beats,
  output logic                             out_sat,
  output logic                             out_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  if (!acc_width_ok(IN_WIDTH, MAX_BEATS, ACC_WIDTH)) begin : g_acc_width_err
    $error("tree_accumulator: ACC_WIDTH too small for IN_WIDTH and MAX_BEATS");
  end

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]       out_beats_q, out_beats_d;
  logic                   out_sat_q, out_sat_d;
  logic                   out_err_q, out_err_d;

  logic                   beat_fire;
  logic                   frame_open;
  logic [ACC_WIDTH-1:0]   in_ext;
  logic [ACC_WIDTH-1:0]   sum;
  logic [SHIFT_W-1:0]     shift_use;
  logic [CNT_W-1:0]       beats_now;
  logic [OUT_WIDTH-1:0]   scaled_data;
  logic                   scaled_sat;

  always_comb begin
    frame_open = (state_q == ACCUM);
    beat_fire  = in_valid && in_ready_q;
    in_ext     = ACC_WIDTH'(sign_extend(64'(in_data), IN_WIDTH));
    // The first beat of a frame starts from zero and takes the live cfg_shift.
    sum        = (frame_open ? acc_q : '0) + in_ext;
    shift_use  = frame_open ? shift_q : cfg_shift;
    beats_now  = (frame_open ? count_q : '0) + CNT_W'(1);
  end

  tree_acc_scale #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_scale (
    .acc_in (sum),
    .shift  (shift_use),
    .data   (scaled_data),
    .sat    (scaled_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    shift_d     = shift_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_sat_d   = out_sat_q;
    out_err_d   = out_err_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (beat_fire) begin
          acc_d   = sum;
          count_d = beats_now;
          shift_d = shift_use;
          if (in_last || (beats_now == MAX_CNT)) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = scaled_data;
            out_beats_d = beats_now;
            out_sat_d   = scaled_sat;
            out_err_d   = !in_last;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          acc_d       = '0;
          count_d     = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_sat_q   <= out_sat_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign out_sat   = out_sat_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_tree_accumulator.sv
// Randomized self-checking bench for tree_accumulator (MAX_BEATS=4) against a
// frame-level arithmetic model; honours TREE_ACC_SAT_EN like the design.
module tb_tree_accumulator;

  localparam int IN_W  = 9;
  localparam int MAXB  = 4;
  localparam int ACC_W = 20;
  localparam int OUT_W = 8;
  localparam int SH_W  = 5;
  localparam int CNT_W = $clog2(MAXB + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic [SH_W-1:0]  cfg_shift;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_beats;
  logic             out_sat;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  tree_accumulator #(
    .IN_WIDTH  (IN_W),
    .MAX_BEATS (MAXB),
    .ACC_WIDTH (ACC_W),
    .OUT_WIDTH (OUT_W),
    .SHIFT_W   (SH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_sat   (out_sat),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame result from plain arithmetic: total, floor-divide by 2^shift, then clamp or wrap.
  function automatic void model(input int vals[8], input int n, input int shift,
                                output longint d, output bit sat);
    longint total, f, w;
    total = 0;
    for (int i = 0; i < n; i++) total += vals[i];
    f = total >>> shift;
`ifdef TREE_ACC_SAT_EN
    if (f > 127)       begin d = 127;  sat = 1'b1; end
    else if (f < -128) begin d = -128; sat = 1'b1; end
    else               begin d = f;    sat = 1'b0; end
`else
    w = f & 255;
    if (w > 127) w -= 256;
    d   = w;
    sat = (w != f);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n beats (last flag on final beat if by_last), then checks the result and handshake.
  task automatic run_frame(input string tag, input int vals[8], input int n,
                           input bit by_last, input int shift, input int hold);
    longint exp_d;
    bit     exp_sat;
    longint held;
    int     waited;
    model(vals, n, shift, exp_d, exp_sat);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid  = 1'b0;
        cfg_shift = SH_W'($urandom);
        step();
      end
      in_valid  = 1'b1;
      in_data   = IN_W'(vals[i]);
      in_last   = by_last && (i == n - 1);
      cfg_shift = (i == 0) ? SH_W'(shift) : SH_W'($urandom);
      check({tag, " in_ready_open"}, longint'(in_ready), 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " latency_valid"}, longint'(out_valid), 1);
    waited = 0;
    while (!out_valid && waited < 10) begin
      step();
      waited++;
    end
    if (!out_valid) check({tag, " result_timeout"}, 0, 1);
    check({tag, " in_ready_hold"}, longint'(in_ready), 0);
    check({tag, " data"},  longint'($signed(out_data)), exp_d);
    check({tag, " beats"}, longint'(out_beats), n);
    check({tag, " sat"},   longint'(out_sat), longint'(exp_sat));
    check({tag, " err"},   longint'(out_err), by_last ? 0 : 1);
    held = longint'($signed(out_data));
    for (int c = 0; c < hold; c++) begin
      step();
      check({tag, " hold_valid"}, longint'(out_valid), 1);
      check({tag, " hold_data"},  longint'($signed(out_data)), held);
      check({tag, " hold_ready"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " release_valid"}, longint'(out_valid), 0);
    check({tag, " release_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    int v[8];
    int n;
    bit by_last;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    cfg_shift = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst in_ready",  longint'(in_ready), 1);
    check("rst out_valid", longint'(out_valid), 0);
    check("rst out_data",  longint'(out_data), 0);
    check("rst out_beats", longint'(out_beats), 0);
    check("rst out_sat",   longint'(out_sat), 0);
    check("rst out_err",   longint'(out_err), 0);
    rst = 1'b0;
    step();

    v = '{10, 20, -5, 7, 0, 0, 0, 0};
    run_frame("t1", v, 4, 1'b1, 0, 0);
    v = '{100, 100, 0, 0, 0, 0, 0, 0};
    run_frame("t2", v, 2, 1'b1, 0, 1);
    v = '{-256, -1, 0, 0, 0, 0, 0, 0};
    run_frame("t3a", v, 2, 1'b1, 1, 0);
    v = '{255, 255, 0, 0, 0, 0, 0, 0};
    run_frame("t3b", v, 2, 1'b1, 2, 0);
    v = '{-40, 90, 3, 0, 0, 0, 0, 0};
    run_frame("t4", v, 3, 1'b1, 0, 5);
    v = '{1, 1, 1, 1, 0, 0, 0, 0};
    run_frame("t5a", v, 4, 1'b0, 0, 0);
    v = '{5, 0, 0, 0, 0, 0, 0, 0};
    run_frame("t5b", v, 1, 1'b1, 0, 0);

    in_valid = 1'b1;
    in_data  = IN_W'(50);
    in_last  = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t6 no_output", longint'(out_valid), 0);
      check("t6 in_ready",  longint'(in_ready), 1);
      step();
    end
    v = '{3, 4, 0, 0, 0, 0, 0, 0};
    run_frame("t6", v, 2, 1'b1, 0, 0);

    for (int f = 0; f < 40; f++) begin
      by_last = ($urandom_range(0, 3) != 0);
      n = by_last ? int'($urandom_range(1, MAXB)) : MAXB;
      for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 511)) - 256;
      run_frame("rand", v, n, by_last, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
